// File: rtl/linear2_pkg.sv
// Shared constants and types for the layer-2 row reader and its dot-product datapath.
// Sizes here match the fixed 10x10 layer-2 weight memory.
package linear2_pkg;

  localparam int DW    = 10;
  localparam int N     = 10;
  localparam int FRAC  = 4;
  localparam int ACC_W = 2 * DW + 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

endpackage

// File: rtl/linear2_dot10.sv
// Combinational N-way signed dot product, floor-shifted by FRAC, saturated to DW bits,
// with optional ReLU. Zero latency; no flow control.
module linear2_dot10
  import linear2_pkg::*;
#(
  parameter int DW_P   = linear2_pkg::DW,
  parameter int N_P    = linear2_pkg::N,
  parameter int FRAC_P = linear2_pkg::FRAC,
  parameter int RELU_P = 0
) (
  input  logic [N_P*DW_P-1:0] w,
  input  logic [N_P*DW_P-1:0] x,
  output logic [DW_P-1:0]     y
);

  localparam int AW = 2 * DW_P + 4;
  localparam logic signed [AW-1:0] HI = AW'(2 ** (DW_P - 1) - 1);
  localparam logic signed [AW-1:0] LO = AW'(-(2 ** (DW_P - 1)));

  logic signed [2*DW_P-1:0] prod [N_P];
  logic signed [AW-1:0]     acc;
  logic signed [AW-1:0]     shifted;

  always_comb begin
    acc = '0;
    for (int j = 0; j < N_P; j++) begin
      prod[j] = $signed(w[j*DW_P +: DW_P]) * $signed(x[j*DW_P +: DW_P]);
      acc     = acc + AW'(prod[j]);
    end
  end

  // Arithmetic shift gives floor rounding for negative sums.
  assign shifted = acc >>> FRAC_P;

  always_comb begin
    y = shifted[DW_P-1:0];
    if (shifted > HI) begin
      y = HI[DW_P-1:0];
    end else if (shifted < LO) begin
      y = LO[DW_P-1:0];
    end
    if ((RELU_P != 0) && shifted[AW-1]) begin
      y = '0;
    end
  end

endmodule

// File: rtl/linear2_row_reader.sv
// Sweeps the layer-2 weight memory for 11 cycles per start and emits one neuron per cycle.
// First result 3 cycles after start; one pass per 13 cycles; start ignored while busy.
module linear2_row_reader
  import linear2_pkg::*;
#(
  parameter int DW   = linear2_pkg::DW,
  parameter int N    = linear2_pkg::N,
  parameter int FRAC = linear2_pkg::FRAC,
  parameter int RELU = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N*DW-1:0] x_vec,
  input  logic [N*DW-1:0] w_row,
  output logic          mem_rd,
  output logic          busy,
  output logic [DW-1:0] y_out,
  output logic [3:0]    y_idx,
  output logic          y_valid,
  output logic          done
);

  // READ lasts N+1 cycles so the memory's row pointer wraps back to row 0.
  localparam logic [3:0] LAST_RD  = 4'(N);
  localparam logic [3:0] LAST_ROW = 4'(N - 1);

  state_t          state;
  logic [3:0]      rd_cnt;
  logic [3:0]      row_cnt;
  logic [N*DW-1:0] x_lat;
  logic            row_vld;
  logic [DW-1:0]   dot_y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rd_cnt <= '0;
      x_lat  <= '0;
      mem_rd <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_lat  <= x_vec;
            rd_cnt <= '0;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
            state  <= READ;
          end
        end
        READ: begin
          if (rd_cnt == LAST_RD) begin
            rd_cnt <= '0;
            mem_rd <= 1'b0;
            state  <= DRAIN;
          end else begin
            rd_cnt <= rd_cnt + 4'd1;
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  linear2_dot10 #(
    .DW_P   (DW),
    .N_P    (N),
    .FRAC_P (FRAC),
    .RELU_P (RELU)
  ) u_dot (
    .w (w_row),
    .x (x_lat),
    .y (dot_y)
  );

  // The read issued with rd_cnt=N only re-aligns the memory pointer; its data is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_vld <= 1'b0;
      row_cnt <= '0;
      y_out   <= '0;
      y_idx   <= '0;
      y_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      row_vld <= mem_rd && (rd_cnt <= LAST_ROW);
      if (row_vld) begin
        y_out   <= dot_y;
        y_idx   <= row_cnt;
        y_valid <= 1'b1;
        done    <= (row_cnt == LAST_ROW);
        row_cnt <= (row_cnt == LAST_ROW) ? 4'd0 : row_cnt + 4'd1;
      end else begin
        y_valid <= 1'b0;
        done    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_linear2_row_reader.sv
// Directed bench: weight memory model with wrapping row pointer, two DUTs (RELU=0/1).
module tb_linear2_row_reader;

  localparam int DW = 10;
  localparam int N  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [N*DW-1:0] x_vec = '0;
  logic [N*DW-1:0] w_row = '0;

  logic          mem_rd0, busy0, y_valid0, done0;
  logic [DW-1:0] y_out0;
  logic [3:0]    y_idx0;
  logic          mem_rd1, busy1, y_valid1, done1;
  logic [DW-1:0] y_out1;
  logic [3:0]    y_idx1;

  always #5 clk = ~clk;

  linear2_row_reader #(.DW(DW), .N(N), .FRAC(4), .RELU(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .x_vec(x_vec), .w_row(w_row),
    .mem_rd(mem_rd0), .busy(busy0), .y_out(y_out0), .y_idx(y_idx0),
    .y_valid(y_valid0), .done(done0)
  );

  linear2_row_reader #(.DW(DW), .N(N), .FRAC(4), .RELU(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .x_vec(x_vec), .w_row(w_row),
    .mem_rd(mem_rd1), .busy(busy1), .y_out(y_out1), .y_idx(y_idx1),
    .y_valid(y_valid1), .done(done1)
  );

  // Memory model: registered read, pointer 0..10 wrapping, re-zeroed by a write.
  logic [N*DW-1:0] mem [0:10];
  logic [3:0]      ptr = '0;
  logic            wr  = 1'b0;

  always @(posedge clk) begin
    if (wr) begin
      ptr <= '0;
    end else if (mem_rd0) begin
      w_row <= mem[ptr];
      ptr   <= (ptr == 4'd10) ? 4'd0 : ptr + 4'd1;
    end
  end

  typedef struct {
    logic [9:0][N*DW-1:0] w;
    logic [N*DW-1:0]      x;
    logic [9:0][DW-1:0]   exp_y;
    logic [9:0][DW-1:0]   exp_r;
  } vec_t;

  vec_t tbl [0:4];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic load(input int vi);
    @(negedge clk);
    for (int i = 0; i < 10; i++) mem[i] = tbl[vi].w[i];
    mem[10] = '0;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Cycle c counts from the start-sampling cycle (c=0). s2: second start cycle,
  // acc2: whether that start is expected to be accepted, rst_c: reset cycle (-1 none).
  task automatic run_pass(input int vi, input int s2, input bit acc2, input bit garble,
                          input int rst_c, input int ncyc);
    logic [N*DW-1:0] xv;
    xv = tbl[vi].x;
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        int p;
        bit live;
        live = (rst_c < 0) || (c <= rst_c);
        p = (acc2 && (c >= s2 + 1)) ? c - s2 : c;
        chk("mem_rd",  32'(mem_rd0),  32'(live && p >= 1 && p <= 11));
        chk("busy",    32'(busy0),    32'(live && p <= 12));
        chk("y_valid", 32'(y_valid0), 32'(live && p >= 3 && p <= 12));
        chk("done",    32'(done0),    32'(live && p == 12));
        chk("relu_vld",32'(y_valid1), 32'(live && p >= 3 && p <= 12));
        if (live && p >= 3 && p <= 12) begin
          chk("y_idx",  32'(y_idx0), 32'(p - 3));
          chk("y_out",  32'(y_out0), 32'(tbl[vi].exp_y[p-3]));
          chk("relu_y", 32'(y_out1), 32'(tbl[vi].exp_r[p-3]));
        end
      end
      start = (c == 0) || (c == s2);
      x_vec = (garble && c >= 5 && c <= 8) ? ~xv : xv;
      rst_n = (c != rst_c);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int ey [0:9];
    ey = '{-50, -40, -30, -20, -10, 0, 10, 20, 30, -2};

    // Diagonal: row i picks x_i scaled by 16/16.
    tbl[0].x = '0;
    for (int i = 0; i < 10; i++) begin
      tbl[0].w[i] = '0;
      tbl[0].w[i][i*DW +: DW] = 10'd16;
      tbl[0].x[i*DW +: DW] = DW'(i);
      tbl[0].exp_y[i] = DW'(i);
      tbl[0].exp_r[i] = DW'(i);
    end
    // Positive and negative saturation.
    for (int i = 0; i < 10; i++) begin
      tbl[1].w[i] = {N{10'd511}};
      tbl[1].exp_y[i] = 10'd511;
      tbl[1].exp_r[i] = 10'd511;
      tbl[2].w[i] = {N{10'h200}};
      tbl[2].exp_y[i] = 10'h200;
      tbl[2].exp_r[i] = 10'd0;
    end
    tbl[1].x = {N{10'd511}};
    tbl[2].x = {N{10'd511}};
    // Floor of -1/16 is -1.
    for (int i = 0; i < 10; i++) begin
      tbl[3].w[i] = '0;
      tbl[3].exp_y[i] = '0;
      tbl[3].exp_r[i] = '0;
    end
    tbl[3].w[0][DW-1:0] = 10'h3FF;
    tbl[3].x = '0;
    tbl[3].x[DW-1:0] = 10'd1;
    tbl[3].exp_y[0] = 10'h3FF;
    // Mixed signs: rows 0..8 all 16*(i-5), row 9 all -3 (-30/16 floors to -2).
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < N; j++) begin
        tbl[4].w[i][j*DW +: DW] = (i == 9) ? DW'(-3) : DW'(16 * (i - 5));
      end
      tbl[4].exp_y[i] = DW'(ey[i]);
      tbl[4].exp_r[i] = (ey[i] < 0) ? '0 : DW'(ey[i]);
    end
    tbl[4].x = {N{10'd1}};

    // Reset held with start asserted.
    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_rd",  32'(mem_rd0),  32'd0);
    chk("rst_busy",    32'(busy0),    32'd0);
    chk("rst_y_valid", 32'(y_valid0), 32'd0);
    chk("rst_done",    32'(done0),    32'd0);
    chk("rst_y_out",   32'(y_out0),   32'd0);
    chk("rst_y_idx",   32'(y_idx0),   32'd0);
    chk("rst_busy_r",  32'(busy1),    32'd0);
    rst_n = 1'b1;
    start = 1'b0;

    for (int vi = 0; vi < 5; vi++) begin
      load(vi);
      run_pass(vi, -100, 1'b0, 1'b0, -1, 14);
    end

    // start at cycle 5 ignored, x_vec garbled after acceptance.
    load(4);
    run_pass(4, 5, 1'b0, 1'b1, -1, 20);

    // Back-to-back: start at cycle 13 accepted, memory pointer wrapped on its own.
    load(0);
    run_pass(0, 13, 1'b1, 1'b0, -1, 27);

    // Reset in cycle 6 aborts the pass; a write then re-aligns the memory.
    load(4);
    run_pass(4, -100, 1'b0, 1'b0, 6, 14);
    load(4);
    run_pass(4, -100, 1'b0, 1'b0, -1, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/linear2_row_reader.md
# linear2_row_reader

Consumer side of the layer-2 weight memory. On a start pulse it latches a 10-element activation vector, drives the memory read strobe for one full 11-cycle row sweep, and computes one output neuron per cycle. Each output is the 10-term dot product of a weight row with the activations, fixed-point rescaled and saturated. It sits between the layer-2 weight memory and the layer-2 output buffer.

## Interface
- Clocking is decided: one clock `clk`; reset `rst_n` is synchronous and active-low.

Parameters:
- `DW`, 10 — weight, activation and output word width (signed two's complement).
- `N`, 10 — rows and weights per row (fixed by the memory).
- `FRAC`, 4 — fractional bits; the accumulator is shifted right by `FRAC`.
- `RELU`, 0 — 1 clamps negative outputs to 0.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: single-cycle request; honoured only while `busy`=0.
- `x_vec` in N*DW: activations; element j is `x_vec[j*DW +: DW]`. Latched on an accepted `start`.
- `w_row` in N*DW: memory row outputs; `dataout`j connects to slice j.
- `mem_rd` out 1: memory read strobe.
- `busy` out 1: a pass is in progress.
- `y_out` out DW: result for neuron `y_idx`.
- `y_idx` out 4: neuron index, 0..9.
- `y_valid` out 1: `y_out`/`y_idx` are valid this cycle.
- `done` out 1: one-cycle pulse, coincident with the `y_idx`=9 result.

## Operation
- Reset values: `mem_rd`, `busy`, `y_valid`, `done` = 0; `y_out` = 0; `y_idx` = 0; FSM = IDLE; all counters = 0; latched x = 0.
- FSM states:
  - IDLE: `start`=1 latches `x_vec` and moves to READ with `rd_cnt`=0.
  - READ: `mem_rd`=1; `rd_cnt` counts 0..10. At `rd_cnt`=10, move to DRAIN.
  - DRAIN: one cycle; returns to IDLE.
- The READ state holds for exactly 11 cycles so that the memory's internal row pointer wraps back to 0. `mem_wt` is never driven by this block.
- Row capture: `row_vld` is `mem_rd` registered with `rd_cnt`≤9. A row is consumed in the cycle after the memory edge that produced it. A row counter increments once per consumed row.
- Arithmetic:
  - Products are signed DW×DW giving 2*DW bits.
  - The sum of N products goes into a 2*DW+4 = 24-bit accumulator. This is exact; no overflow is possible.
  - The sum is arithmetic-shifted right by FRAC (floor), then saturated to [−2^(DW−1), 2^(DW−1)−1].
  - If RELU=1, negative results become 0.
- Outputs are registered: `y_out`, `y_idx` and `y_valid` update one cycle after a row is consumed.
- `start` while `busy`=1 is ignored. `x_vec` changes after acceptance have no effect.
- Upstream must not assert memory writes while `busy`=1.
- Reset mid-pass: all outputs take their reset values on the next edge, and no `done` is issued. The memory row pointer is only re-zeroed by a write or by a wrap. Therefore at least one weight write must precede the next `start`. This block does not detect a violation.

## Timing
- Cycle 0: `start` sampled.
- Cycles 1–11: `mem_rd`=1.
- Cycles 2–11: rows 0..9 present on `w_row`.
- Cycles 3–12: `y_valid`=1 with `y_idx` 0..9.
- Cycle 12: `done`=1.
- `busy`=1 in cycles 1–12.
- Earliest next `start` is cycle 13 (`busy`=0). Throughput is one pass per 13 cycles.
- `start` to first result latency: 3 cycles.

## Structure
- Shared package `linear2_pkg`: `DW`, `N`, `FRAC`, `ACC_W`=2*DW+4, the FSM state enum (IDLE/READ/DRAIN), and the saturation bounds.
- Sub-module `linear2_dot10`: combinational N-way signed multiply and adder tree, plus shift, saturate and optional ReLU. The parent owns the FSM, counters and output registers.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `start`=1. Expect all outputs 0, `busy`=0, `mem_rd`=0.
- Diagonal weights, w[i][j]=16 if i==j else 0, and x_j=j:
  - expect `y_out`=i at `y_idx`=i in cycles 3..12;
  - `mem_rd` high in exactly cycles 1..11;
  - `done` only in cycle 12.
- Saturation:
  - all w=511, all x=511 → every `y_out`=511;
  - all w=−512, x=511 → −512 (0x200);
  - the same with RELU=1 → 0.
- Floor: w[0][0]=−1, x_0=1, all else 0 → `y_out`=−1 (0x3FF) at `y_idx`=0; all other outputs 0.
- Protocol:
  - `start` in cycle 5 → ignored; no second pass;
  - `start` in cycle 13 → accepted; `mem_rd` high in cycles 14..24; results repeat identically.
- Mid-pass reset: `rst_n`=0 in cycle 6 → from cycle 7 `busy`=0, `mem_rd`=0, `y_valid`=0, no `done`. After one weight write and a new `start`, expect the full correct 10-result pass.
